// File: rtl/bam_sweep_master.sv
// BAM duty-cycle sweep master: steps a duty code from start to end, writing the
// BAM DCYCLE/CONFIG registers once per point and dwelling between points.
module bam_sweep_master #(
  parameter int unsigned DCYCLE_ADDR = 131,
  parameter int unsigned CONFIG_ADDR = 132,
  parameter int unsigned DWELL_W     = 24
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [15:0]        i_start_duty,
  input  logic [15:0]        i_end_duty,
  input  logic [15:0]        i_step,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [2:0]         i_prescale,
  output logic               o_we,
  output logic [31:0]        o_address,
  output logic [31:0]        o_write_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_aborted
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWStop  = 3'd1;
  localparam logic [2:0] StWDuty  = 3'd2;
  localparam logic [2:0] StWRun   = 3'd3;
  localparam logic [2:0] StDwell  = 3'd4;
  localparam logic [2:0] StWFinal = 3'd5;

  localparam logic [31:0] DcycleAddr = 32'(DCYCLE_ADDR);
  localparam logic [31:0] ConfigAddr = 32'(CONFIG_ADDR);
  localparam logic [DWELL_W-1:0] DwellOne = DWELL_W'(1);

  logic [2:0]         state_q, state_d;
  logic [15:0]        cur_duty_q, cur_duty_d;
  logic [15:0]        start_q, start_d;
  logic [15:0]        end_q, end_d;
  logic [15:0]        step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         prescale_q, prescale_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic [16:0]        next_sum;
  logic               last_point;

  // 17-bit sum so a large step saturates at the end code instead of wrapping
  assign next_sum   = {1'b0, cur_duty_q} + {1'b0, step_q};
  assign last_point = (cur_duty_q == end_q) || (step_q == 16'd0) || (start_q >= end_q);

  always_comb begin
    state_d    = state_q;
    cur_duty_d = cur_duty_q;
    start_d    = start_q;
    end_d      = end_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_start && !i_stop) begin
          start_d    = i_start_duty;
          end_d      = i_end_duty;
          step_d     = i_step;
          dwell_d    = i_dwell;
          prescale_d = i_prescale;
          cur_duty_d = i_start_duty;
          abort_d    = 1'b0;
          state_d    = StWStop;
        end
      end
      StWStop: begin
        state_d = i_stop ? StWFinal : StWDuty;
        abort_d = i_stop;
      end
      StWDuty: begin
        state_d = i_stop ? StWFinal : StWRun;
        abort_d = i_stop;
      end
      StWRun: begin
        cnt_d   = (dwell_q == '0) ? DwellOne : dwell_q;
        state_d = i_stop ? StWFinal : StDwell;
        abort_d = i_stop;
      end
      StDwell: begin
        cnt_d = cnt_q - DwellOne;
        if (i_stop) begin
          state_d = StWFinal;
          abort_d = 1'b1;
        end else if (cnt_q <= DwellOne) begin
          if (last_point) begin
            state_d = StWFinal;
          end else begin
            cur_duty_d = (next_sum > {1'b0, end_q}) ? end_q : next_sum[15:0];
            state_d    = StWStop;
          end
        end
      end
      StWFinal: begin
        state_d   = StIdle;
        done_d    = !abort_q;
        aborted_d = abort_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= StIdle;
      cur_duty_q <= '0;
      start_q    <= '0;
      end_q      <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      prescale_q <= '0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_duty_q <= cur_duty_d;
      start_q    <= start_d;
      end_q      <= end_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  // Bus is decoded straight from state so reset clears it in the same cycle
  always_comb begin
    o_we         = 1'b0;
    o_address    = '0;
    o_write_data = '0;
    case (state_q)
      StWStop, StWFinal: begin
        o_we         = 1'b1;
        o_address    = ConfigAddr;
        o_write_data = {28'b0, prescale_q, 1'b0};
      end
      StWDuty: begin
        o_we         = 1'b1;
        o_address    = DcycleAddr;
        o_write_data = {16'b0, cur_duty_q};
      end
      StWRun: begin
        o_we         = 1'b1;
        o_address    = ConfigAddr;
        o_write_data = {28'b0, prescale_q, 1'b1};
      end
      default: ;
    endcase
  end

  assign o_busy    = (state_q != StIdle);
  assign o_done    = done_q;
  assign o_aborted = aborted_q;

endmodule

// File: tb/tb_bam_sweep_master.sv
// Self-checking bench for bam_sweep_master: expected bus writes are queued when a
// sweep is launched and popped by a negedge monitor as the DUT writes.
module tb_bam_sweep_master;

  localparam int unsigned DCYCLE_ADDR = 131;
  localparam int unsigned CONFIG_ADDR = 132;
  localparam int unsigned DWELL_W     = 24;

  logic               clk = 1'b0;
  logic               arst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [15:0]        start_duty = '0;
  logic [15:0]        end_duty = '0;
  logic [15:0]        step = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [2:0]         prescale = '0;
  logic               o_we;
  logic [31:0]        o_address;
  logic [31:0]        o_write_data;
  logic               o_busy;
  logic               o_done;
  logic               o_aborted;

  int checks = 0;
  int fails  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  int busy_cycles, idle_busy, done_cnt, abort_cnt;
  bit mon_en = 1'b0;

  bam_sweep_master #(
    .DCYCLE_ADDR(DCYCLE_ADDR),
    .CONFIG_ADDR(CONFIG_ADDR),
    .DWELL_W    (DWELL_W)
  ) dut (
    .i_clk       (clk),
    .i_arst_n    (arst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_start_duty(start_duty),
    .i_end_duty  (end_duty),
    .i_step      (step),
    .i_dwell     (dwell),
    .i_prescale  (prescale),
    .o_we        (o_we),
    .o_address   (o_address),
    .o_write_data(o_write_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_aborted   (o_aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (o_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%0h, required no write",
                   o_address, o_write_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({o_address, o_write_data} !== mon_exp) begin
            fails++;
            $display("FAIL bus_write: got addr=%0d data=0x%0h, required addr=%0d data=0x%0h",
                     o_address, o_write_data, mon_exp[63:32], mon_exp[31:0]);
          end
        end
      end else if (o_address !== 32'd0 || o_write_data !== 32'd0) begin
        fails++;
        $display("FAIL bus_idle_zero: got addr=%0d data=0x%0h, required 0/0",
                 o_address, o_write_data);
      end
      if (o_busy === 1'b1) begin
        busy_cycles++;
        if (o_we !== 1'b1) idle_busy++;
      end
      if (o_done === 1'b1) done_cnt++;
      if (o_aborted === 1'b1) abort_cnt++;
    end
  end

  task automatic clear_mon();
    busy_cycles = 0;
    idle_busy   = 0;
    done_cnt    = 0;
    abort_cnt   = 0;
  endtask

  // Independent sweep model: queues every expected write and returns timing totals
  task automatic push_sweep(input int s, input int e, input int st, input int dw, input int pre,
                            output int exp_busy, output int exp_idle);
    int cur;
    int pts;
    int d;
    d   = (dw == 0) ? 1 : dw;
    cur = s;
    pts = 0;
    while (1) begin
      exp_q.push_back({32'(CONFIG_ADDR), 32'(pre * 2)});
      exp_q.push_back({32'(DCYCLE_ADDR), 32'(cur)});
      exp_q.push_back({32'(CONFIG_ADDR), 32'(pre * 2 + 1)});
      pts++;
      if (cur == e || st == 0 || s >= e) break;
      cur = (cur + st > e) ? e : cur + st;
    end
    exp_q.push_back({32'(CONFIG_ADDR), 32'(pre * 2)});
    exp_busy = pts * (3 + d) + 1;
    exp_idle = pts * d;
  endtask

  // Called at #1 after a posedge; returns #1 after the edge that samples start
  task automatic pulse_start(input int s, input int e, input int st, input int dw, input int pre);
    start_duty = 16'(s);
    end_duty   = 16'(e);
    step       = 16'(st);
    dwell      = DWELL_W'(dw);
    prescale   = 3'(pre);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input string name, input int s, input int e, input int st,
                           input int dw, input int pre);
    int eb;
    int ei;
    int n;
    clear_mon();
    push_sweep(s, e, st, dw, pre, eb, ei);
    pulse_start(s, e, st, dw, pre);
    checks++;
    if (o_we !== 1'b1 || o_address !== 32'(CONFIG_ADDR)) begin
      fails++;
      $display("FAIL %s_first_write: we=%b addr=%0d, required we=1 addr=%0d",
               name, o_we, o_address, CONFIG_ADDR);
    end
    // Scramble inputs and re-request start while busy; neither may disturb the sweep
    start_duty = 16'h1234;
    end_duty   = 16'hFFFF;
    step       = 16'h0001;
    dwell      = '0;
    prescale   = 3'd7;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (o_busy === 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s_timeout: busy after %0d cycles, required idle", name, n);
    end
    checks++;
    if (o_done !== 1'b1 || o_aborted !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse: done=%b aborted=%b, required 1/0", name, o_done, o_aborted);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_after_done: done=%b busy=%b, required 0/0", name, o_done, o_busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_writes_left: %0d expected writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (busy_cycles != eb) begin
      fails++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", name, busy_cycles, eb);
    end
    checks++;
    if (idle_busy != ei) begin
      fails++;
      $display("FAIL %s_dwell_cycles: got %0d, required %0d", name, idle_busy, ei);
    end
    checks++;
    if (done_cnt != 1 || abort_cnt != 0) begin
      fails++;
      $display("FAIL %s_status_counts: done=%0d aborted=%0d, required 1/0",
               name, done_cnt, abort_cnt);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    checks++;
    if ({o_we, o_address, o_write_data, o_busy, o_done, o_aborted} !== 67'd0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=0x%0h busy=%b done=%b aborted=%b, required 0",
               o_we, o_address, o_write_data, o_busy, o_done, o_aborted);
    end
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: busy=%b we=%b, required 0/0", o_busy, o_we);
    end
  endtask

  task automatic test_start_with_stop();
    start_duty = 16'h0100;
    end_duty   = 16'h0200;
    step       = 16'h0100;
    start      = 1'b1;
    stop       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_we !== 1'b0) begin
      fails++;
      $display("FAIL start_with_stop: busy=%b we=%b, required 0/0", o_busy, o_we);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    exp_q.push_back({32'(CONFIG_ADDR), 32'h4});
    exp_q.push_back({32'(DCYCLE_ADDR), 32'h1000});
    exp_q.push_back({32'(CONFIG_ADDR), 32'h5});
    exp_q.push_back({32'(CONFIG_ADDR), 32'h4});
    pulse_start(16'h1000, 16'h3000, 16'h1000, 10, 2);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    stop = 1'b1;  // third dwell cycle
    @(posedge clk);
    #1;
    stop = 1'b0;
    checks++;
    if (o_we !== 1'b1 || o_address !== 32'(CONFIG_ADDR) || o_write_data !== 32'h4) begin
      fails++;
      $display("FAIL abort_stop_write: we=%b addr=%0d data=0x%0h, required 1/%0d/0x4",
               o_we, o_address, o_write_data, CONFIG_ADDR);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_aborted !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_pulse: aborted=%b done=%b busy=%b, required 1/0/0",
               o_aborted, o_done, o_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (abort_cnt != 1 || done_cnt != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL abort_counts: aborted=%0d done=%0d left=%0d, required 1/0/0",
               abort_cnt, done_cnt, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_sweep();
    int writes;
    mon_en = 1'b0;
    pulse_start(16'h0400, 16'h0800, 16'h0100, 3, 1);
    @(posedge clk);
    #1;
    checks++;
    if (o_address !== 32'(DCYCLE_ADDR)) begin
      fails++;
      $display("FAIL rst_mid_in_duty: addr=%0d, required %0d", o_address, DCYCLE_ADDR);
    end
    arst_n = 1'b0;
    #1;
    checks++;
    if ({o_we, o_address, o_write_data, o_busy, o_done, o_aborted} !== 67'd0) begin
      fails++;
      $display("FAIL rst_mid_outputs: we=%b addr=%0d data=0x%0h busy=%b, required 0",
               o_we, o_address, o_write_data, o_busy);
    end
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    writes = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (o_we !== 1'b0 || o_busy !== 1'b0) writes++;
    end
    checks++;
    if (writes != 0) begin
      fails++;
      $display("FAIL rst_mid_quiet: %0d active cycles after release, required 0", writes);
    end
    mon_en = 1'b1;
    run_sweep("rst_restart", 16'h0400, 16'h0600, 16'h0100, 2, 1);
  endtask

  initial begin
    test_reset();
    test_start_with_stop();
    mon_en = 1'b1;
    run_sweep("single_point", 16'h8000, 16'h8000, 16'h0100, 4, 0);
    run_sweep("three_points", 16'h1000, 16'h3000, 16'h1000, 2, 1);
    run_sweep("saturate", 16'hF000, 16'hFFFF, 16'h8000, 1, 3);
    test_abort();
    test_reset_mid_sweep();
    run_sweep("dwell_zero", 16'h2222, 16'h9000, 16'h0000, 0, 5);
    run_sweep("start_above_end", 16'h9000, 16'h1000, 16'h0100, 3, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
